// File: rtl/spi_flash_reader.sv
// spi_flash_reader: picorv32 native-bus responder that serves 32-bit reads from SPI flash,
// holding chip select low across sequential words so instruction fetches skip the command phase.
module spi_flash_reader #(
   parameter int          SCK_DIV    = 2,
   parameter int          CSH_CYCLES = 4,
   parameter logic [7:0]  READ_CMD   = 8'h03,
   parameter logic [23:0] ADDR_MASK  = 24'hFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic [31:0] mem_addr,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        spi_csn,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        streaming
);
   localparam logic [2:0] S_IDLE = 3'd0, S_CSH = 3'd1, S_SHIFT = 3'd2, S_DONE = 3'd3, S_STREAM = 3'd4;
   logic [2:0]  state_q, state_d;
   logic [31:0] csh_cnt_q, csh_cnt_d, div_cnt_q, div_cnt_d;
   logic [6:0]  bit_cnt_q, bit_cnt_d;
   logic [31:0] sh_out_q, sh_out_d, sh_in_q, sh_in_d, rdata_q, rdata_d;
   logic [23:0] next_addr_q, next_addr_d, addr;
   logic        csn_q, csn_d, sck_q, sck_d, mosi_q, mosi_d, ready_q, ready_d, abort_q, abort_d;
   logic        rd, wr, idle_ok, seq;
   logic        unused_hi;
   assign unused_hi = ^mem_addr[31:24];
   always_comb begin
      addr        = mem_addr[23:0] & ADDR_MASK & 24'hFF_FFFC;
      rd          = sel && !ready_q && mem_wstrb == 4'd0;
      wr          = sel && !ready_q && mem_wstrb != 4'd0;
      idle_ok     = state_q == S_IDLE || state_q == S_STREAM || (state_q == S_CSH && csh_cnt_q >= CSH_CYCLES);
      seq         = state_q == S_STREAM && addr == next_addr_q;
      state_d     = state_q;
      csh_cnt_d   = csh_cnt_q;
      div_cnt_d   = div_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      sh_out_d    = sh_out_q;
      sh_in_d     = sh_in_q;
      rdata_d     = rdata_q;
      next_addr_d = next_addr_q;
      csn_d       = csn_q;
      sck_d       = sck_q;
      mosi_d      = mosi_q;
      abort_d     = abort_q;
      ready_d     = 1'b0;
      if (idle_ok && wr)
         ready_d = 1'b1;
      else if (idle_ok && rd && (state_q != S_STREAM || seq)) begin
         state_d     = S_SHIFT;
         csn_d       = 1'b0;
         div_cnt_d   = 32'd0;
         abort_d     = 1'b0;
         bit_cnt_d   = seq ? 7'd32 : 7'd0;
         sh_out_d    = seq ? 32'd0 : {READ_CMD, addr};
         mosi_d      = seq ? 1'b0 : READ_CMD[7];
         next_addr_d = (addr + 24'd4) & ADDR_MASK;
      end else if (rd && state_q == S_STREAM) begin
         state_d   = S_CSH;
         csn_d     = 1'b1;
         csh_cnt_d = 32'd1;
      end else if (state_q == S_CSH) begin
         state_d   = idle_ok ? S_IDLE : S_CSH;
         csh_cnt_d = idle_ok ? csh_cnt_q : csh_cnt_q + 32'd1;
      end
      // miso is captured on the edge that raises sck; mosi only moves on the falling edge
      if (state_q == S_SHIFT) begin
         abort_d   = abort_q | !sel;
         div_cnt_d = div_cnt_q + 32'd1;
         if (div_cnt_q == SCK_DIV - 1) begin
            sck_d   = 1'b1;
            sh_in_d = {sh_in_q[30:0], spi_miso};
         end
         if (div_cnt_q == 2 * SCK_DIV - 1) begin
            div_cnt_d = 32'd0;
            sck_d     = 1'b0;
            mosi_d    = sh_out_q[30];
            sh_out_d  = {sh_out_q[30:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 7'd1;
            state_d   = bit_cnt_q == 7'd63 ? S_DONE : S_SHIFT;
         end
      end
      if (state_q == S_DONE) begin
         state_d = S_STREAM;
         if (sel && !abort_q) begin
            ready_d = 1'b1;
            rdata_d = {sh_in_q[7:0], sh_in_q[15:8], sh_in_q[23:16], sh_in_q[31:24]};
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         csh_cnt_q   <= CSH_CYCLES;
         div_cnt_q   <= 32'd0;
         bit_cnt_q   <= 7'd0;
         sh_out_q    <= 32'd0;
         sh_in_q     <= 32'd0;
         rdata_q     <= 32'd0;
         next_addr_q <= 24'd0;
         csn_q       <= 1'b1;
         sck_q       <= 1'b0;
         mosi_q      <= 1'b0;
         ready_q     <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         csh_cnt_q   <= csh_cnt_d;
         div_cnt_q   <= div_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         sh_out_q    <= sh_out_d;
         sh_in_q     <= sh_in_d;
         rdata_q     <= rdata_d;
         next_addr_q <= next_addr_d;
         csn_q       <= csn_d;
         sck_q       <= sck_d;
         mosi_q      <= mosi_d;
         ready_q     <= ready_d;
         abort_q     <= abort_d;
      end
   end
   assign mem_ready = ready_q;
   assign mem_rdata = rdata_q;
   assign spi_csn   = csn_q;
   assign spi_sck   = sck_q;
   assign spi_mosi  = mosi_q;
   assign streaming = state_q == S_STREAM;
endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: random and directed reads/writes against a behavioural SPI flash,
// with a scoreboard queue popped by a monitor whenever mem_ready is seen.
module tb_spi_flash_reader;
   localparam int D = 2, CSH = 4;
   logic clk = 0, reset = 1, sel = 0;
   logic [31:0] mem_addr = 0;
   logic [3:0] mem_wstrb = 0;
   logic mem_ready, spi_csn, spi_sck, spi_mosi, streaming;
   logic spi_miso = 0;
   logic [31:0] mem_rdata;

   spi_flash_reader #(.SCK_DIV(D), .CSH_CYCLES(CSH)) dut (
      .clk(clk), .reset(reset), .sel(sel), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .spi_csn(spi_csn), .spi_sck(spi_sck),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .streaming(streaming)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int lat;
      int t0;
      bit wr;
      int cmds;
      logic [31:0] cmd;
      int sck;
      bit csn_low;
   } exp_t;
   exp_t exp_q[$];
   exp_t e;
   int cyc = 0, tot = 0, bad = 0, timeouts = 0, sck_bad = 0, mosi_bad = 0, hi_run = 0;
   bit done = 0;

   // flash contents: the known boot word at 0x100000, a scrambled pattern elsewhere
   function automatic logic [7:0] byte_at(input logic [23:0] a);
      logic [31:0] w;
      w = 32'h6F00_0013;
      if (a[23:2] == 22'h04_0000) return w[8*a[1:0] +: 8];
      return (a[7:0] * 8'd37) ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'hA5;
   endfunction

   logic prev_csn = 1, prev_sck = 0;
   int fbit = 0, fsub = 0, cmd_cnt = 0, sck_rises = 0;
   logic [31:0] fcmd = 0, last_cmd = 0;
   logic [23:0] fptr = 0;
   logic [7:0] fb;
   always @(spi_csn or spi_sck) begin
      if (spi_sck === 1'b1 && prev_sck === 1'b0) sck_rises++;
      if (spi_csn === 1'b0 && prev_csn === 1'b1) begin
         fbit = 0;
         fsub = 0;
      end else if (spi_csn === 1'b0 && spi_sck === 1'b1 && prev_sck === 1'b0) begin
         if (fbit < 32) begin
            fcmd = {fcmd[30:0], spi_mosi};
            fbit++;
            if (fbit == 32) begin
               cmd_cnt++;
               last_cmd = fcmd;
               fptr = fcmd[23:0];
            end
         end else if (spi_mosi !== 1'b0) mosi_bad++;
      end else if (spi_csn === 1'b0 && spi_sck === 1'b0 && prev_sck === 1'b1 && fbit >= 32) begin
         fb = byte_at(fptr);
         spi_miso = fb[7-fsub];
         fsub++;
         if (fsub == 8) begin
            fsub = 0;
            fptr++;
         end
      end
      prev_csn = spi_csn;
      prev_sck = spi_sck;
   end

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
      tot++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", n, got, want, cyc);
      end
   endtask

   always @(posedge clk) begin
      #1;
      cyc++;
      if (reset) begin
         chk("reset_pins{csn,sck,mosi,ready,streaming}", {27'd0, spi_csn, spi_sck, spi_mosi, mem_ready, streaming}, 32'b10000);
         chk("reset_rdata", mem_rdata, 32'd0);
      end
      if (mem_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            tot++;
            bad++;
            $display("FAIL ready_without_request: got mem_ready=1 want 0 (cycle %0d)", cyc);
         end else begin
            e = exp_q.pop_front();
            chk(e.wr ? "write_rdata_held" : "read_rdata", mem_rdata, e.data);
            chk("ready_latency", cyc - e.t0, e.lat);
            chk("command_count", cmd_cnt, e.cmds);
            if (!e.wr) chk("last_command", last_cmd, e.cmd);
            if (!e.wr) chk("streaming_after_read", {31'd0, streaming}, 32'd1);
            if (e.wr) chk("write_sck_rises", sck_rises, e.sck);
            if (e.csn_low) chk("write_csn_low", {31'd0, spi_csn}, 32'd0);
         end
      end
      if (spi_csn === 1'b1 && spi_sck !== 1'b0) sck_bad++;
      if (spi_csn === 1'b1) hi_run++;
      else begin
         if (hi_run > 0) chk("csn_high_min", (hi_run >= CSH) ? 32'd1 : 32'd0, 32'd1);
         hi_run = 0;
      end
      if (done) begin
         chk("timeouts", timeouts, 0);
         chk("sck_high_while_csn_high", sck_bad, 0);
         chk("mosi_nonzero_in_data", mosi_bad, 0);
         chk("pending_expects", exp_q.size(), 0);
         $display("test done: total=%0d bad=%0d", tot, bad);
         $finish;
      end
   end

   logic [31:0] m_last_data = 0, m_last_cmd = 0;
   logic [23:0] m_next = 0;
   bit m_stream = 0;
   int m_cmds = 0;

   task automatic do_req(input logic [31:0] a, input logic [3:0] ws, input int gap);
      exp_t x;
      logic [23:0] m;
      bit s;
      int n;
      m = a[23:0] & 24'hFF_FFFC;
      s = m_stream && m == m_next;
      x.t0 = cyc;
      x.wr = ws != 0;
      x.sck = sck_rises;
      x.csn_low = m_stream && ws != 0;
      if (ws != 0) begin
         x.data = m_last_data;
         x.lat = 1;
      end else begin
         x.lat = s ? 2 + 64*D : m_stream ? 2 + 128*D + CSH : 2 + 128*D;
         if (!s) begin
            m_cmds++;
            m_last_cmd = {8'h03, m};
         end
         m_last_data = {byte_at(m + 24'd3), byte_at(m + 24'd2), byte_at(m + 24'd1), byte_at(m)};
         x.data = m_last_data;
         m_stream = 1;
         m_next = m + 24'd4;
      end
      x.cmds = m_cmds;
      x.cmd = m_last_cmd;
      exp_q.push_back(x);
      sel = 1;
      mem_addr = a;
      mem_wstrb = ws;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (mem_ready !== 1'b1 && n < 2000);
      if (mem_ready !== 1'b1) begin
         timeouts++;
         $display("FAIL timeout: no mem_ready for addr %h after %0d cycles", a, n);
      end
      sel = 0;
      mem_wstrb = 0;
      repeat (gap + 1) @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      reset = 1;
      sel = 0;
      mem_wstrb = 0;
      repeat (n) @(negedge clk);
      reset = 0;
      m_stream = 0;
      m_last_data = 0;
      repeat (CSH + 2) @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      do_reset(3);
      do_req(32'h0010_0000, 4'h0, 0);
      do_req(32'h0010_0004, 4'h0, 0);
      do_req(32'h0010_0040, 4'h0, 1);
      do_req(32'h0010_0044, 4'hF, 0);
      do_req(32'h0010_0044, 4'h0, 2);
      do_reset(1);
      sel = 1;
      mem_addr = 32'h0010_0080;
      mem_wstrb = 0;
      m_cmds++;
      repeat (162) @(negedge clk);
      do_reset(1);
      do_req(32'h0010_0008, 4'h0, 0);
      do_req(32'h00FF_FFFC, 4'h0, 0);
      do_req(32'h0100_0000, 4'h0, 1);
      for (int i = 0; i < 24; i++) begin
         int r, g;
         logic [31:0] a, rnd;
         r = $urandom_range(0, 3);
         g = $urandom_range(0, 3);
         rnd = $urandom;
         a = {rnd[31:24], m_next};
         if (r == 3) a[1:0] = rnd[1:0];
         if (r == 1) do_req(rnd, 4'h0, g);
         else if (r == 2) do_req(rnd, 4'($urandom_range(1, 15)), g);
         else do_req(a, 4'h0, g);
      end
      done = 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end
endmodule
